// File: rtl/dom_shared_sqscmul_gf2.sv
// rtl/dom_shared_sqscmul_gf2.sv - DOM-masked GF(2^2) square-scale-multiply, Q = sqsc(X^Y) ^ X*Y
//
// Sits in the GF(2^4) inverter of the Canright masked AES S-box. Normal basis (W^2,W):
// bit1 = coefficient of W^2, bit0 = coefficient of W, nu = W^2 = W+1.
//
// Ports:
//   ClkxCI  - clock, rising edge
//   RstxBI  - asynchronous active-low reset, clears every register
//   _XxDI   - X shares, share i at [2i+1:2i]
//   _YxDI   - Y shares, same packing
//   _ZxDI   - fresh randomness, one 2-bit element per share pair (i<j), pair k at [2k+1:2k]
//   _BxDI   - fresh ring-refresh masks, B_i at [2i+1:2i]
//   _QxDO   - Q shares, same packing; only the XOR of all shares is meaningful
module dom_shared_sqscmul_gf2 #(
  parameter int PIPELINED                = 1,
  parameter int FIRST_ORDER_OPTIMIZATION = 1,
  parameter int SHARES                   = 2
) (
  input  logic                         ClkxCI,
  input  logic                         RstxBI,
  input  logic [2*SHARES-1:0]          _XxDI,
  input  logic [2*SHARES-1:0]          _YxDI,
  input  logic [SHARES*(SHARES-1)-1:0] _ZxDI,
  input  logic [2*SHARES-1:0]          _BxDI,
  output logic [2*SHARES-1:0]          _QxDO
);

  // Off-diagonal (i != j) cross terms only, so no storage is wasted on the diagonal.
  localparam int NCROSS = SHARES * (SHARES - 1);

  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    logic e;
    e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
  endfunction

  // Square followed by scaling with nu; linear, so it can be applied share-wise.
  function automatic logic [1:0] gf4_sqsc(input logic [1:0] a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  // Index of the unordered pair {i,j} in the (0,1),(0,2)..(1,2).. ordering of _ZxDI.
  function automatic int pair_idx(input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return (lo * (2 * SHARES - lo - 1)) / 2 + (hi - lo - 1);
  endfunction

  // Slot of ordered cross term (i,j), i != j, in the packed cross-term vectors.
  function automatic int cross_idx(input int i, input int j);
    return i * (SHARES - 1) + ((j < i) ? j : j - 1);
  endfunction

  logic [2*NCROSS-1:0] cross_d, cross_q;
  logic [2*SHARES-1:0] inner_d, inner_q;
  logic [2*SHARES-1:0] sqsc_d, sqsc_q;
  logic [2*SHARES-1:0] inner_sel, sqsc_sel;

  always_comb begin
    logic [1:0] xi;
    logic [1:0] yi;
    logic [1:0] s;
    cross_d = '0;
    inner_d = '0;
    sqsc_d  = '0;
    for (int i = 0; i < SHARES; i++) begin
      xi = _XxDI[2*i +: 2];
      yi = _YxDI[2*i +: 2];
      s  = gf4_sqsc(xi ^ yi);
      sqsc_d[2*i +: 2] = s;
      // Ring refresh: B_i enters share i and share i-1, so it cancels on recombination.
      inner_d[2*i +: 2] = gf4_mul(xi, yi) ^ _BxDI[2*i +: 2] ^ _BxDI[2*((i + 1) % SHARES) +: 2]
                          ^ ((FIRST_ORDER_OPTIMIZATION != 0) ? s : 2'b00);
      for (int j = 0; j < SHARES; j++) begin
        if (j != i) begin
          // Z_k is used in both C_ij and C_ji, so it cancels in the recombined Q.
          cross_d[2*cross_idx(i, j) +: 2] = gf4_mul(xi, _YxDI[2*j +: 2]) ^ _ZxDI[2*pair_idx(i, j) +: 2];
        end
      end
    end
  end

  // Cross-domain terms always pass a register before recombination (glitch barrier).
  // Inner and sqsc registers are only consumed when the configuration selects them.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      cross_q <= '0;
      inner_q <= '0;
      sqsc_q  <= '0;
    end else begin
      cross_q <= cross_d;
      inner_q <= inner_d;
      sqsc_q  <= sqsc_d;
    end
  end

  assign inner_sel = (PIPELINED != 0) ? inner_q : inner_d;
  assign sqsc_sel  = (FIRST_ORDER_OPTIMIZATION != 0) ? '0 :
                     ((PIPELINED != 0) ? sqsc_q : sqsc_d);

  always_comb begin
    logic [1:0] acc;
    _QxDO = '0;
    for (int i = 0; i < SHARES; i++) begin
      acc = inner_sel[2*i +: 2] ^ sqsc_sel[2*i +: 2];
      for (int j = 0; j < SHARES; j++) begin
        if (j != i) begin
          acc = acc ^ cross_q[2*cross_idx(i, j) +: 2];
        end
      end
      _QxDO[2*i +: 2] = acc;
    end
  end

endmodule

// File: tb/tb_dom_shared_sqscmul_gf2.sv
// tb/tb_dom_shared_sqscmul_gf2.sv - self-checking bench for dom_shared_sqscmul_gf2 (2 shares)
module tb_dom_shared_sqscmul_gf2;

  logic       ClkxCI = 1'b0;
  logic       RstxBI;
  logic [3:0] _XxDI;
  logic [3:0] _YxDI;
  logic [1:0] _ZxDI;
  logic [3:0] _BxDI;
  logic [3:0] _QxDO;

  int vectors     = 0;
  int miscompares = 0;
  logic [1:0] exp_q[$];

  dom_shared_sqscmul_gf2 #(
    .PIPELINED(1),
    .FIRST_ORDER_OPTIMIZATION(1),
    .SHARES(2)
  ) dut (
    .ClkxCI(ClkxCI),
    .RstxBI(RstxBI),
    ._XxDI (_XxDI),
    ._YxDI (_YxDI),
    ._ZxDI (_ZxDI),
    ._BxDI (_BxDI),
    ._QxDO (_QxDO)
  );

  always #5 ClkxCI = ~ClkxCI;

  function automatic logic [1:0] ref_mul(input logic [1:0] a, input logic [1:0] b);
    logic m;
    m = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ m, (a[0] & b[0]) ^ m};
  endfunction

  function automatic logic [1:0] ref_sqsc(input logic [1:0] a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present shared inputs with fresh Z/B and queue the expected recombined result.
  task automatic set_inputs(input logic [1:0] x0, input logic [1:0] x1,
                            input logic [1:0] y0, input logic [1:0] y1);
    logic [1:0] x;
    logic [1:0] y;
    x = x0 ^ x1;
    y = y0 ^ y1;
    _XxDI = {x1, x0};
    _YxDI = {y1, y0};
    _ZxDI = 2'($urandom);
    _BxDI = 4'($urandom);
    exp_q.push_back(ref_sqsc(x ^ y) ^ ref_mul(x, y));
  endtask

  task automatic drive(input logic [1:0] x0, input logic [1:0] x1,
                       input logic [1:0] y0, input logic [1:0] y1);
    @(negedge ClkxCI);
    set_inputs(x0, x1, y0, y1);
  endtask

  task automatic collect(input string tag);
    @(posedge ClkxCI);
    #1;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed output with empty scoreboard, expected a queued result", tag);
    end else begin
      check(tag, {2'b00, _QxDO[1:0] ^ _QxDO[3:2]}, {2'b00, exp_q.pop_front()});
    end
  endtask

  task automatic apply(input string tag, input logic [1:0] x0, input logic [1:0] x1,
                       input logic [1:0] y0, input logic [1:0] y1);
    drive(x0, x1, y0, y1);
    collect(tag);
  endtask

  initial begin
    logic [7:0] v;
    logic [3:0] first_shares;
    logic       changed;

    RstxBI = 1'b0;
    _XxDI  = 4'h0;
    _YxDI  = 4'h0;
    _ZxDI  = 2'h0;
    _BxDI  = 4'h0;
    #2;
    check("reset_q", _QxDO, 4'h0);
    _XxDI = 4'hB;
    _YxDI = 4'h6;
    _ZxDI = 2'h3;
    _BxDI = 4'h9;
    @(posedge ClkxCI);
    #1;
    check("reset_hold", _QxDO, 4'h0);
    @(negedge ClkxCI);
    RstxBI = 1'b1;

    // Equal operands: pure multiply path, sharings chosen non-trivially.
    apply("eq_x1y1", 2'd3, 2'd2, 2'd0, 2'd1);
    apply("eq_x2y2", 2'd1, 2'd3, 2'd2, 2'd0);
    apply("eq_x3y3", 2'd1, 2'd2, 2'd3, 2'd0);

    // Y = 0: pure square-scale path.
    apply("sqsc_x1", 2'd2, 2'd3, 2'd1, 2'd1);
    apply("sqsc_x2", 2'd0, 2'd2, 2'd3, 2'd3);
    apply("sqsc_x3", 2'd3, 2'd0, 2'd2, 2'd2);

    // Exhaustive over all shares, one new vector every cycle (no bubbles).
    for (int n = 0; n < 256; n++) begin
      v = 8'(n);
      apply("exhaustive", v[1:0], v[3:2], v[5:4], v[7:6]);
    end

    // Random back-to-back stream.
    for (int n = 0; n < 24; n++) begin
      apply("stream", 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
    end

    // Asynchronous reset mid-stream: in-flight result discarded.
    drive(2'd1, 2'd3, 2'd2, 2'd2);
    @(posedge ClkxCI);
    #2;
    RstxBI = 1'b0;
    #1;
    check("rst_async", _QxDO, 4'h0);
    exp_q.delete();
    @(posedge ClkxCI);
    #1;
    check("rst_held", _QxDO, 4'h0);
    @(negedge ClkxCI);
    RstxBI = 1'b1;
    set_inputs(2'd2, 2'd1, 2'd1, 2'd0);
    collect("rst_release");
    apply("post_rst", 2'd3, 2'd1, 2'd0, 2'd2);

    // Fixed X, Y with fresh masks: shares move, recombined value does not.
    changed = 1'b0;
    first_shares = 4'h0;
    for (int n = 0; n < 10; n++) begin
      apply("fixed_xy", 2'd2, 2'd3, 2'd1, 2'd3);
      if (n == 0) first_shares = _QxDO;
      else if (_QxDO !== first_shares) changed = 1'b1;
    end
    check("share_refresh", {3'b000, changed}, 4'h1);

    check("scoreboard_drained", 4'(exp_q.size()), 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
